// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying words out of fifo_stream_reader.
// master drives valid/data, slave drives ready.
interface fifo_stream_reader_if #(
    parameter int DW = 8
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller with a 2-word registered output buffer.
// Define FIFO_RD_CNT_EN to add the word_cnt delivered-word counter.
module fifo_stream_reader #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    input  logic                 fifo_rvalid,
    input  logic [DW-1:0]        fifo_rdata,
    fifo_stream_reader_if.master m
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CW-1:0]        word_cnt
`endif
);

    if (CW < 1) begin : g_cw_chk
        $error("CW must be at least 1");
    end

    logic [1:0]    occ_q, occ_d;
    logic          infl_q;
    logic          valid_q, valid_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;
    logic [1:0]    credit;
    logic          pop;
    logic          push;

    assign m.m_valid = valid_q;
    assign m.m_data  = head_q;

    assign pop    = valid_q && m.m_ready;
    assign credit = occ_q + {1'b0, infl_q};

    // One extra read is allowed when full only if a word leaves now.
    assign fifo_r_en = !rst && en && !flush && !fifo_empty &&
                       ((credit < 2'd2) || (credit == 2'd2 && pop));

    // A return without a matching issue is a protocol error and is dropped.
    assign push = fifo_rvalid && infl_q && !flush;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_rdata;
                end else begin
                    skid_d = fifo_rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = fifo_rdata;
                end else begin
                    head_d = fifo_rdata;
                end
            end
            default: ;
        endcase
        if (flush) begin
            occ_d = 2'd0;
        end
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= 2'd0;
            infl_q  <= 1'b0;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            infl_q  <= fifo_r_en;
            valid_q <= valid_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d    = pop ? cnt_q + 1'b1 : cnt_q;
    assign word_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model with read drops, stream scoreboard.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic          fifo_rvalid = 1'b0;
    logic [DW-1:0] fifo_rdata = '0;
`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] word_cnt;
`endif

    fifo_stream_reader_if #(.DW(DW)) s_if ();

    fifo_stream_reader #(.DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_rvalid (fifo_rvalid),
        .fifo_rdata  (fifo_rdata),
        .m           (s_if.master)
`ifdef FIFO_RD_CNT_EN
        ,
        .word_cnt    (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int rd_cnt = 0;
    int dlv_cnt = 0;
    int lost = 0;
    int drop_req = 0;
    int drops_done = 0;

    // FIFO model: registered read data, optional dropped reads.
    always @(posedge clk) begin
        fifo_rvalid <= 1'b0;
        if (fifo_r_en && fq.size() > 0) begin
            if (drops_done < drop_req) begin
                drops_done <= drops_done + 1;
            end else begin
                fifo_rdata  <= fq.pop_front();
                fifo_rvalid <= 1'b1;
                rd_cnt      <= rd_cnt + 1;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor: order check and buffer bound.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        int held;
        if (!rst) begin
            held = rd_cnt - dlv_cnt - lost;
            total++;
            if (held > 2) begin
                bad++;
                $display("FAIL held: got %0d want <=2", held);
            end
            if (s_if.m_valid && s_if.m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got %0h want none", s_if.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_if.m_data !== e) begin
                        bad++;
                        $display("FAIL order: got %0h want %0h", s_if.m_data, e);
                    end
                end
                dlv_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        step();
    endtask

    task automatic discard(input int want);
        int n;
        n = rd_cnt - dlv_cnt - lost;
        total++;
        if (want >= 0 && n !== want) begin
            bad++;
            $display("FAIL discard_cnt: got %0d want %0d", n, want);
        end
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        lost += n;
    endtask

    task automatic test_reset();
        s_if.m_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        #1;
        total++;
        if (s_if.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %b want 0", s_if.m_valid);
        end
        total++;
        if (s_if.m_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_data: got %0h want 0", s_if.m_data);
        end
        total++;
        if (fifo_r_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_ren: got %b want 0", fifo_r_en);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_throughput();
        logic er[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic ev[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] ed[6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        fq.push_back(8'h11); exp_q.push_back(8'h11);
        fq.push_back(8'h22); exp_q.push_back(8'h22);
        fq.push_back(8'h33); exp_q.push_back(8'h33);
        step();
        en = 1'b1;
        s_if.m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (fifo_r_en !== er[c]) begin
                bad++;
                $display("FAIL tp_ren c%0d: got %b want %b", c, fifo_r_en, er[c]);
            end
            total++;
            if (s_if.m_valid !== ev[c]) begin
                bad++;
                $display("FAIL tp_valid c%0d: got %b want %b", c, s_if.m_valid, ev[c]);
            end
            if (ev[c]) begin
                total++;
                if (s_if.m_data !== ed[c]) begin
                    bad++;
                    $display("FAIL tp_data c%0d: got %0h want %0h", c, s_if.m_data, ed[c]);
                end
            end
            step();
        end
        en = 1'b0;
    endtask

    task automatic test_backpressure();
        int ren = 0;
        load(8'h44, 3);
        en = 1'b1;
        s_if.m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            ren += int'(fifo_r_en);
            if (c >= 2) begin
                total++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== 8'h44) begin
                    bad++;
                    $display("FAIL bp_hold c%0d: got %b/%0h want 1/44", c, s_if.m_valid, s_if.m_data);
                end
            end
            step();
        end
        total++;
        if (ren !== 2) begin
            bad++;
            $display("FAIL bp_reads: got %0d want 2", ren);
        end
        s_if.m_ready = 1'b1;
        repeat (6) step();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bp_left: got %0d want 0", exp_q.size());
        end
        en = 1'b0;
    endtask

    task automatic test_drop();
        load(8'h71, 4);
        drop_req++;
        en = 1'b1;
        s_if.m_ready = 1'b1;
        repeat (10) step();
        total++;
        if (drops_done !== drop_req) begin
            bad++;
            $display("FAIL drop_seen: got %0d want %0d", drops_done, drop_req);
        end
        total++;
        if (exp_q.size() !== 0 || fq.size() !== 0) begin
            bad++;
            $display("FAIL drop_left: got %0d want 0", exp_q.size() + fq.size());
        end
        en = 1'b0;
    endtask

    task automatic test_flush();
        load(8'hA0, 8);
        en = 1'b1;
        s_if.m_ready = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++;
        if (s_if.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL fl1_valid: got %b want 0", s_if.m_valid);
        end
        discard(2);
        s_if.m_ready = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        #1;
        total++;
        if (fifo_r_en !== 1'b0) begin
            bad++;
            $display("FAIL fl2_ren: got %b want 0", fifo_r_en);
        end
        step();
        flush = 1'b0;
        #1;
        total++;
        if (s_if.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL fl2_valid: got %b want 0", s_if.m_valid);
        end
        discard(-1);
        repeat (14) step();
        total++;
        if (exp_q.size() !== 0 || fq.size() !== 0) begin
            bad++;
            $display("FAIL fl_left: got %0d want 0", exp_q.size() + fq.size());
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        load(8'hB0, 6);
        en = 1'b1;
        s_if.m_ready = 1'b1;
        repeat (3) step();
        total++;
        if (s_if.m_valid !== 1'b1) begin
            bad++;
            $display("FAIL rm_pre: got %b want 1", s_if.m_valid);
        end
        rst = 1'b1;
        s_if.m_ready = 1'b0;
        step();
        #1;
        total++;
        if (s_if.m_valid !== 1'b0 || s_if.m_data !== 8'h00 || fifo_r_en !== 1'b0) begin
            bad++;
            $display("FAIL rm_state: got %b/%0h/%b want 0/0/0", s_if.m_valid, s_if.m_data, fifo_r_en);
        end
        discard(-1);
        rst = 1'b0;
        s_if.m_ready = 1'b1;
        repeat (12) step();
        total++;
        if (exp_q.size() !== 0 || s_if.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL rm_left: got %0d/%b want 0/0", exp_q.size(), s_if.m_valid);
        end
        en = 1'b0;
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_word_cnt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++;
        if (word_cnt !== 4'd0) begin
            bad++;
            $display("FAIL cnt_rst: got %0d want 0", word_cnt);
        end
        load(8'hC0, 17);
        en = 1'b1;
        s_if.m_ready = 1'b1;
        repeat (24) step();
        total++;
        if (word_cnt !== 4'd1) begin
            bad++;
            $display("FAIL cnt_wrap: got %0d want 1", word_cnt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++;
        if (word_cnt !== 4'd1) begin
            bad++;
            $display("FAIL cnt_flush: got %0d want 1", word_cnt);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        s_if.m_ready = 1'b0;
        test_reset();
        test_throughput();
        test_backpressure();
        test_drop();
        test_flush();
        test_reset_mid();
`ifdef FIFO_RD_CNT_EN
        test_word_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
